// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding and default bit period.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  // 100 MHz system clock, 115200 baud
  localparam int CLKS_PER_BIT_DEF = 868;

endpackage

// File: rtl/uart_tx_baud_counter.sv
// Bit-period counter: tick marks the last clk of a bit, tick_next the clk before it.
module baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick,
  output logic tick_next
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] NEXT = W'(CLKS_PER_BIT - 2);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick      = (cnt_q == LAST);
  assign tick_next = (cnt_q == NEXT);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with fully registered tx/tx_busy/byte_done.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_ready,
  input  logic [7:0] TX_data,
  output logic       tx,
  output logic       byte_done,
  output logic       tx_busy
);

  uart_state_e state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick, tick_next, clear;

  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .tick     (tick),
    .tick_next(tick_next)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: if (tx_ready) begin
        state_d = START;
        shreg_d = TX_data;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shreg_d   = {1'b0, shreg_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts on each state change; held at zero while idle so a
  // frame always begins on a fresh bit period.
  assign clear = (state_d != state_q) || (state_q == IDLE);

  // Outputs are computed from the next state so they land in flops
  // aligned with the state they describe.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && tick_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx        = tx_q;
  assign tx_busy   = busy_q;
  assign byte_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model plus serial decoder.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int FL  = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] TX_data = 8'h00;
  logic       tx, byte_done, tx_busy;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int busy_seen = 0;

  // reference model: one active frame, its byte and cycle offset
  bit         m_act = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] exp_q[$];
  logic [FL-1:0] hist = '1;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_ready (tx_ready),
    .TX_data  (TX_data),
    .tx       (tx),
    .byte_done(byte_done),
    .tx_busy  (tx_busy)
  );

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [7:0] dec, eb;
    @(posedge clk);
    if (!rst_n) begin
      if (m_act) void'(exp_q.pop_back());
      m_act = 1'b0;
    end else if (m_act) begin
      m_t++;
      if (m_t == FL) m_act = 1'b0;
    end else if (tx_ready) begin
      m_act  = 1'b1;
      m_t    = 0;
      m_byte = TX_data;
      exp_q.push_back(TX_data);
    end
    #1;
    chk("tx", {31'b0, tx}, {31'b0, (m_act ? frame_bit(m_byte, m_t / CPB) : 1'b1)});
    chk("tx_busy", {31'b0, tx_busy}, {31'b0, m_act});
    chk("byte_done", {31'b0, byte_done}, {31'b0, (m_act && m_t == FL - 1)});
    hist = {hist[FL-2:0], tx};
    if (tx_busy === 1'b1) busy_seen++;
    if (byte_done === 1'b1) begin
      done_seen++;
      chk("done_has_expected", {31'b0, (exp_q.size() > 0)}, 32'd1);
      if (exp_q.size() > 0) begin
        eb = exp_q.pop_front();
        for (int k = 0; k < 8; k++) dec[k] = hist[FL-1-((k+1)*CPB + CPB/2)];
        chk("decode", {24'b0, dec}, {24'b0, eb});
        chk("start_bit", {31'b0, hist[FL-1-CPB/2]}, 32'd0);
        chk("stop_bit", {31'b0, hist[0]}, 32'd1);
      end
    end
  endtask

  initial begin
    int d0, b0, n, low_cnt;

    // reset
    rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, tx_busy}, 32'd0);
    chk("rst_done", {31'b0, byte_done}, 32'd0);
    rst_n = 1'b1;

    // single A5 frame from a one-cycle request
    repeat (2) cyc();
    d0 = done_seen; b0 = busy_seen;
    tx_ready = 1'b1; TX_data = 8'hA5;
    cyc();
    tx_ready = 1'b0; TX_data = 8'h00;
    repeat (44) cyc();
    chk("a5_done_count", done_seen - d0, 32'd1);
    chk("a5_busy_cycles", busy_seen - b0, 32'd40);

    // back-to-back: 0F then F0 swapped in on the byte_done edge
    tx_ready = 1'b1; TX_data = 8'h0F;
    cyc();
    n = 0;
    while (byte_done !== 1'b1 && n < 100) begin cyc(); n++; end
    chk("b2b_wait_done", {31'b0, byte_done}, 32'd1);
    cyc();
    TX_data = 8'hF0;
    chk("b2b_gap_tx", {31'b0, tx}, 32'd1);
    chk("b2b_gap_busy", {31'b0, tx_busy}, 32'd0);
    cyc();
    chk("b2b_start_tx", {31'b0, tx}, 32'd0);
    chk("b2b_start_busy", {31'b0, tx_busy}, 32'd1);
    tx_ready = 1'b0;
    repeat (45) cyc();

    // data and request toggling during a 3C frame
    tx_ready = 1'b1; TX_data = 8'h3C;
    cyc();
    for (int i = 0; i < 37; i++) begin
      TX_data  = ~TX_data;
      tx_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    tx_ready = 1'b0;
    repeat (8) cyc();

    // reset during data bit 3, then 55
    tx_ready = 1'b1; TX_data = 8'($urandom);
    cyc();
    tx_ready = 1'b0;
    repeat (17) cyc();
    d0 = done_seen;
    rst_n = 1'b0;
    cyc();
    chk("abort_tx", {31'b0, tx}, 32'd1);
    chk("abort_busy", {31'b0, tx_busy}, 32'd0);
    rst_n = 1'b1; tx_ready = 1'b1; TX_data = 8'h55;
    cyc();
    chk("post_rst_start", {31'b0, tx}, 32'd0);
    tx_ready = 1'b0;
    repeat (44) cyc();
    chk("abort_done_count", done_seen - d0, 32'd1);

    // 00 then FF framing
    tx_ready = 1'b1; TX_data = 8'h00;
    cyc();
    TX_data = 8'hFF;
    repeat (41) cyc();
    tx_ready = 1'b0;
    repeat (45) cyc();

    // random requests and data
    for (int i = 0; i < 800; i++) begin
      tx_ready = ($urandom_range(0, 3) == 0);
      TX_data  = 8'($urandom);
      cyc();
    end
    tx_ready = 1'b0;
    repeat (45) cyc();

    // long idle after reset
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    d0 = done_seen; low_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      TX_data = 8'($urandom);
      cyc();
      if (tx !== 1'b1) low_cnt++;
    end
    chk("idle_tx_low_cycles", low_cnt, 32'd0);
    chk("idle_done_count", done_seen - d0, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
